cache_controller: RTL

Two-way set-associative, write-through, no-write-allocate data cache controller between the pipeline MEM stage and the external SRAM controller. Reads that hit complete combinationally with no stall. Misses and all writes sequence a single SRAM transaction and hold `ready` low, which freezes the pipeline until the transaction completes. Replacement uses one LRU bit per set.

---
 rtl/cache_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - two-way set-associative write-through, no-write-allocate data cache controller
// Read hits answer combinationally; misses and stores run one SRAM transaction while ready is held low.
module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_en,
  input  logic        MEM_W_en,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = 3 + IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_RD_MISS, S_WR} state_t;

  state_t             r_state;
  state_t             w_next;

  logic [SETS-1:0]    r_valid [2];
  logic [SETS-1:0]    r_lru;
  logic [TAG_W-1:0]   r_tag   [2][SETS];
  logic [63:0]        r_data  [2][SETS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_word;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_hit_way;
  logic               w_victim;
  logic [63:0]        w_hit_line;
  logic [31:0]        w_hit_word;
  logic [31:0]        w_fill_word;
  logic               w_is_read;
  logic               w_rd_hit;
  logic               w_fill;
  logic               w_wr_hit;

  assign w_idx       = address[3 +: IDX_W];
  assign w_tag       = address[TAG_LSB +: TAG_W];
  assign w_word      = address[2];
  assign w_hit0      = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1      = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit       = w_hit0 || w_hit1;
  assign w_hit_way   = w_hit1;
  assign w_victim    = r_lru[w_idx];
  assign w_hit_line  = w_hit1 ? r_data[1][w_idx] : r_data[0][w_idx];
  assign w_hit_word  = w_word ? w_hit_line[63:32] : w_hit_line[31:0];
  assign w_fill_word = w_word ? sram_rdata[63:32] : sram_rdata[31:0];

  // A simultaneous load and store is handled purely as a store.
  assign w_is_read   = MEM_R_en && !MEM_W_en;
  assign w_rd_hit    = (r_state == S_IDLE) && w_is_read && w_hit;
  assign w_fill      = (r_state == S_RD_MISS) && sram_ready;
  assign w_wr_hit    = (r_state == S_WR) && sram_ready && w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (MEM_W_en) begin
          w_next = S_WR;
        end else if (MEM_R_en && !w_hit) begin
          w_next = S_RD_MISS;
        end
      end
      S_RD_MISS: if (sram_ready) w_next = S_IDLE;
      S_WR:      if (sram_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready        = 1'b1;
    rdata        = 32'h0;
    sram_address = 32'h0;
    sram_wdata   = 32'h0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MEM_W_en) begin
          ready = 1'b0;
        end else if (MEM_R_en) begin
          if (w_hit) begin
            rdata = w_hit_word;
          end else begin
            ready = 1'b0;
          end
        end
      end
      S_RD_MISS: begin
        sram_read    = 1'b1;
        sram_address = {address[31:3], 3'b000};
        ready        = sram_ready;
        if (sram_ready) begin
          rdata = w_fill_word;
        end
      end
      S_WR: begin
        sram_write   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        ready        = sram_ready;
      end
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_lru      <= '0;
    end else if (w_fill) begin
      r_valid[w_victim][w_idx] <= 1'b1;
      r_lru[w_idx]             <= ~w_victim;
    end else if (w_rd_hit || w_wr_hit) begin
      r_lru[w_idx] <= ~w_hit_way;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[w_victim][w_idx]  <= w_tag;
        r_data[w_victim][w_idx] <= sram_rdata;
      end else if (w_wr_hit) begin
        if (w_word) begin
          r_data[w_hit_way][w_idx][63:32] <= wdata;
        end else begin
          r_data[w_hit_way][w_idx][31:0]  <= wdata;
        end
      end
    end
  end

endmodule
